// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output writer.
package conv_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DONE     = 2'd2
    } frame_state_t;

    localparam int PIX_W   = 12;
    localparam int WORD_W  = 16;
    localparam int SOF_BIT = 15;
    localparam int BORDER  = 2;

    // Build an output word: {sof, zero padding, pixel}
    function automatic logic [WORD_W-1:0] pack_word(input logic sof,
                                                    input logic [PIX_W-1:0] pix);
        logic [WORD_W-1:0] w;
        w              = '0;
        w[SOF_BIT]     = sof;
        w[PIX_W-1:0]   = pix;
        return w;
    endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Small synchronous FIFO with the head entry presented on rd_data.
// Storage is reset so the head reads as zero straight out of reset.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module conv_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             iCLK,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    // Qualify the requests against the occupancy flags
    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || do_rd);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry and flags
    always_comb begin
        rd_data = mem[rd_ptr];
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
    end

endmodule

// File: rtl/conv_frame_writer.sv
// Tracks raster position of the Sobel output stream, masks incomplete
// 3x3 windows, tags start-of-frame and queues 16-bit words for SDRAM.
// Build option: CONV_BORDER_MASK_EN zeroes border pixels (x<2 or y<2);
// without it every pixel passes unmodified.
// Output handshake: a word transfers on a rising edge where oVALID and
// iREADY are both high; oVALID/oDATA stay stable while oVALID && !iREADY.
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              iCLK,
    input  logic              rst_n,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              iREADY,
    output logic              oVALID,
    output logic [WORD_W-1:0] oDATA,
    output logic              oFRAME_DONE,
    output logic              oOVERFLOW
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    frame_state_t      state;
    frame_state_t      state_nxt;
    logic              fval_q;
    logic              fval_rise;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [XW-1:0]     x_pos;
    logic [YW-1:0]     y_pos;
    logic              pix_cnt_en;
    logic              excess;
    logic              last_pix;
    logic              drop;
    logic              wr_en;
    logic [PIX_W-1:0]  pix_field;
    logic [WORD_W-1:0] word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rd_en;

    // Frame-valid edge detector and FSM state register
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            fval_q <= 1'b0;
            state  <= WAIT_SOF;
        end else begin
            fval_q <= iFVAL;
            state  <= state_nxt;
        end
    end

    assign fval_rise = iFVAL && !fval_q;

    // Next-state logic; a rising iFVAL always (re)starts a frame
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_SOF: if (fval_rise) state_nxt = ACTIVE;
            ACTIVE:   if (fval_rise) state_nxt = ACTIVE;
            DONE: begin
                if (fval_rise)   state_nxt = ACTIVE;
                else if (!iFVAL) state_nxt = WAIT_SOF;
            end
            default:  state_nxt = WAIT_SOF;
        endcase
        if (last_pix) state_nxt = DONE;
    end

    // FSM outputs: which pixels count, which are excess, and where they sit
    always_comb begin
        pix_cnt_en = iDVAL && (fval_rise || state == ACTIVE);
        excess     = iDVAL && !fval_rise && state == DONE;
        x_pos      = fval_rise ? '0 : x_cnt;
        y_pos      = fval_rise ? '0 : y_cnt;
        last_pix   = pix_cnt_en && (x_pos == XW'(IMG_W-1)) && (y_pos == YW'(IMG_H-1));
    end

    // Raster counters; cleared by a frame start, advanced by every counted pixel
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_cnt_en) begin
            if (x_pos == XW'(IMG_W-1)) begin
                x_cnt <= '0;
                y_cnt <= (y_pos == YW'(IMG_H-1)) ? '0 : y_pos + YW'(1);
            end else begin
                x_cnt <= x_pos + XW'(1);
                y_cnt <= y_pos;
            end
        end else if (fval_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end
    end

    // Border masking and word packing for the current pixel
    always_comb begin
`ifdef CONV_BORDER_MASK_EN
        if (x_pos < XW'(BORDER) || y_pos < YW'(BORDER)) pix_field = '0;
        else                                            pix_field = pixel_in;
`else
        pix_field = pixel_in;
`endif
        word = pack_word((x_pos == '0) && (y_pos == '0), pix_field);
    end

    // A full FIFO only frees a slot this cycle if the head is being taken
    always_comb begin
        oVALID = !fifo_empty;
        rd_en  = oVALID && iREADY;
        drop   = pix_cnt_en && fifo_full && !iREADY;
        wr_en  = pix_cnt_en && !drop;
    end

    conv_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .iCLK    (iCLK),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (word),
        .rd_en   (rd_en),
        .rd_data (oDATA),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Registered status: frame-done pulse and sticky overflow
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            oFRAME_DONE <= 1'b0;
            oOVERFLOW   <= 1'b0;
        end else begin
            oFRAME_DONE <= last_pix;
            if (drop || excess) oOVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Directed bench for conv_frame_writer on an 8x4 frame with a 4-entry FIFO.
module tb_conv_frame_writer;

    localparam int W = 8;
    localparam int H = 4;

    logic        iCLK = 1'b0;
    logic        rst_n = 1'b1;
    logic        iFVAL = 1'b0;
    logic        iDVAL = 1'b0;
    logic [11:0] pixel_in = '0;
    logic        iREADY = 1'b1;
    logic        oVALID;
    logic [15:0] oDATA;
    logic        oFRAME_DONE;
    logic        oOVERFLOW;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int spurious = 0;
    logic [15:0] exp_q[$];

`ifdef CONV_BORDER_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    conv_frame_writer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (4)
    ) dut (
        .iCLK        (iCLK),
        .rst_n       (rst_n),
        .iFVAL       (iFVAL),
        .iDVAL       (iDVAL),
        .pixel_in    (pixel_in),
        .iREADY      (iREADY),
        .oVALID      (oVALID),
        .oDATA       (oDATA),
        .oFRAME_DONE (oFRAME_DONE),
        .oOVERFLOW   (oOVERFLOW)
    );

    // Clock
    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected word for frame index idx carrying raw pixel pix
    function automatic logic [15:0] exp_word(input int idx, input logic [11:0] pix);
        logic [11:0] f;
        int x, y;
        x = idx % W;
        y = idx / W;
        f = pix;
        if (MASK && (x < 2 || y < 2)) f = '0;
        return {(idx == 0), 3'b000, f};
    endfunction

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send(input logic [11:0] pix, input int idx, input bit keep);
        iFVAL    = 1'b1;
        iDVAL    = 1'b1;
        pixel_in = pix;
        if (keep) exp_q.push_back(exp_word(idx, pix));
        cyc();
        iDVAL = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // Scoreboard: compare every accepted word and count frame-done pulses
    always @(negedge iCLK) begin
        if (rst_n && oVALID && iREADY) begin
            if (exp_q.size() == 0) spurious++;
            else check("word", oDATA, exp_q.pop_front());
        end
        if (oFRAME_DONE) done_cnt++;
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_valid", oVALID, 0);
        check("rst_data", oDATA, 0);
        check("rst_done", oFRAME_DONE, 0);
        check("rst_ovf", oOVERFLOW, 0);
        rst_n = 1'b1;
        cyc();

        // Full frame, iREADY high
        for (int i = 0; i < W*H; i++) begin
            send(12'h100 + 12'(i), i, 1'b1);
            if (i == 0)  check("f1_word0", oDATA, MASK ? 16'h8000 : 16'h8100);
            if (i == 1)  check("f1_word1", oDATA, MASK ? 16'h0000 : 16'h0101);
            if (i == 18) check("f1_word18", oDATA, 16'h0112);
        end
        check("f1_done_hi", oFRAME_DONE, 1);
        cyc();
        check("f1_done_lo", oFRAME_DONE, 0);
        iFVAL = 1'b0;
        cyc();
        wait_drain();
        check("f1_done_cnt", done_cnt, 1);
        check("f1_ovf", oOVERFLOW, 0);

        // Restart mid-frame at pixel 13
        for (int i = 0; i < 13; i++) send(12'h200 + 12'(i), i, 1'b1);
        iFVAL = 1'b0;
        cyc();
        send(12'h200, 0, 1'b1);
        check("rs_word0", oDATA, MASK ? 16'h8000 : 16'h8200);
        for (int i = 1; i < W*H; i++) send(12'h200 + 12'(i), i, 1'b1);
        iFVAL = 1'b0;
        cyc();
        wait_drain();
        check("rs_done_cnt", done_cnt, 2);

        // Backpressure: 6 pixels into a 4-entry FIFO with iREADY low
        iREADY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(12'h300 + 12'(i), i, i < 4);
            if (i == 3) check("bp_ovf_before", oOVERFLOW, 0);
            if (i == 4) check("bp_ovf_after", oOVERFLOW, 1);
        end
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", oVALID, 1);
            check("bp_hold_data", oDATA, MASK ? 16'h8000 : 16'h8300);
            cyc();
        end
        iREADY = 1'b1;
        wait_drain();
        for (int i = 6; i < W*H; i++) send(12'h300 + 12'(i), i, 1'b1);
        check("bp_done", oFRAME_DONE, 1);
        iFVAL = 1'b0;
        cyc();
        wait_drain();
        check("bp_done_cnt", done_cnt, 3);

        // Excess pixels after the last one of the frame
        do_reset();
        check("ex_ovf_reset", oOVERFLOW, 0);
        for (int i = 0; i < W*H; i++) send(12'h400 + 12'(i), i, 1'b1);
        check("ex_ovf_before", oOVERFLOW, 0);
        for (int i = 0; i < 3; i++) send(12'hfff, 0, 1'b0);
        check("ex_ovf_after", oOVERFLOW, 1);
        iFVAL = 1'b0;
        cyc();
        wait_drain();
        check("ex_valid", oVALID, 0);
        check("ex_done_cnt", done_cnt, 4);

        // Reset with three words queued
        iREADY = 1'b0;
        for (int i = 0; i < 3; i++) send(12'h500 + 12'(i), i, 1'b0);
        check("rm_valid_before", oVALID, 1);
        rst_n = 1'b0;
        iFVAL = 1'b0;
        #1;
        check("rm_valid", oVALID, 0);
        check("rm_data", oDATA, 0);
        check("rm_ovf", oOVERFLOW, 0);
        cyc();
        rst_n  = 1'b1;
        iREADY = 1'b1;
        cyc();
        iDVAL = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        iDVAL = 1'b0;
        check("rm_ignored_valid", oVALID, 0);
        check("rm_ignored_ovf", oOVERFLOW, 0);
        send(12'h600, 0, 1'b1);
        check("rm_word0", oDATA, MASK ? 16'h8000 : 16'h8600);
        for (int i = 1; i < W*H; i++) send(12'h600 + 12'(i), i, 1'b1);
        iFVAL = 1'b0;
        cyc();
        wait_drain();
        check("rm_done_cnt", done_cnt, 5);
        check("spurious", spurious, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
